mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates one block-wide memory port between an instruction cache
//   (read-only) and a data cache (read or write-back). One transaction is in
//   flight at a time. A transaction is granted from IDLE, waits until the
//   memory has raised and then dropped MEM_BUSYWAIT, completes, and then
//   spends one RELEASE cycle. Only during RELEASE is the served requester's
//   busywait lowered. When both caches request together, the port that was
//   not served last wins.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   i_read_i              I-cache block read request
//   i_address_i           I-cache block address
//   i_readdata_o          block returned to the I-cache (registered)
//   i_busywait_o          I-cache stall (combinational)
//   d_read_i, d_write_i   D-cache read / write-back request
//   d_address_i           D-cache block address
//   d_writedata_i         D-cache write-back block
//   d_readdata_o          block returned to the D-cache (registered)
//   d_busywait_o          D-cache stall (combinational)
//   mem_read_o/write_o    memory strobes
//   mem_address_o         memory block address
//   mem_writedata_o       memory write data
//   mem_readdata_i        memory read data
//   mem_busywait_i        memory busy
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_address_i,
  output logic [DATA_W-1:0] i_readdata_o,
  output logic              i_busywait_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic [DATA_W-1:0] d_writedata_i,
  output logic [DATA_W-1:0] d_readdata_o,
  output logic              d_busywait_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_writedata_o,
  input  logic [DATA_W-1:0] mem_readdata_i,
  input  logic              mem_busywait_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Encoding of the last_grant flag.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t            state_q, state_d;
  logic              busy_seen_q, busy_seen_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0] d_readdata_q, d_readdata_d;

  logic i_req;
  logic d_req;
  logic in_grant;
  logic complete;

  assign i_req    = i_read_i;
  assign d_req    = d_read_i | d_write_i;
  assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);
  // The memory must have been seen busy at least once before a low
  // busywait can mean "done"; otherwise the grant edge itself, where the
  // memory has not yet reacted to the strobe, would look like completion.
  assign complete = in_grant && busy_seen_q && !mem_busywait_i;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    busy_seen_d  = busy_seen_q;
    last_grant_d = last_grant_q;
    i_readdata_d = i_readdata_q;
    d_readdata_d = d_readdata_q;

    if (in_grant && mem_busywait_i) begin
      busy_seen_d = 1'b1;
    end else if (complete) begin
      busy_seen_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = (last_grant_q == LAST_D) ? GRANT_I : GRANT_D;
        end else if (i_req) begin
          state_d = GRANT_I;
        end else if (d_req) begin
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        if (complete) begin
          state_d      = RELEASE;
          last_grant_d = LAST_I;
          // A withdrawn request still completes, but its data is dropped.
          if (i_read_i) begin
            i_readdata_d = mem_readdata_i;
          end
        end
      end
      GRANT_D: begin
        if (complete) begin
          state_d      = RELEASE;
          last_grant_d = LAST_D;
          // Read+write together was issued as a write only: no data return.
          if (d_read_i && !d_write_i) begin
            d_readdata_d = mem_readdata_i;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory command decode
  always_comb begin
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_address_o   = '0;
    mem_writedata_o = '0;
    case (state_q)
      GRANT_I: begin
        mem_read_o    = 1'b1;
        mem_address_o = i_address_i;
      end
      GRANT_D: begin
        mem_read_o      = d_read_i & ~d_write_i;
        mem_write_o     = d_write_i;
        mem_address_o   = d_address_i;
        mem_writedata_o = d_writedata_i;
      end
      default: ;
    endcase
  end

  // A requester stalls until the RELEASE cycle of its own transaction.
  assign i_busywait_o = i_req & ~((state_q == RELEASE) && (last_grant_q == LAST_I));
  assign d_busywait_o = d_req & ~((state_q == RELEASE) && (last_grant_q == LAST_D));

  assign i_readdata_o = i_readdata_q;
  assign d_readdata_o = d_readdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      busy_seen_q  <= 1'b0;
      last_grant_q <= LAST_D;   // first tie after reset goes to the I-cache
      i_readdata_q <= '0;
      d_readdata_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_seen_q  <= busy_seen_d;
      last_grant_q <= last_grant_d;
      i_readdata_q <= i_readdata_d;
      d_readdata_q <= d_readdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A small memory model raises busywait
//   on a strobe and holds it for five cycles. Single and dual-port
//   transactions come from a vector table; alternation, request withdrawal
//   and mid-transaction reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [5:0]  i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        d_read;
  logic        d_write;
  logic [5:0]  d_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .i_read_i       (i_read),
    .i_address_i    (i_address),
    .i_readdata_o   (i_readdata),
    .i_busywait_o   (i_busywait),
    .d_read_i       (d_read),
    .d_write_i      (d_write),
    .d_address_i    (d_address),
    .d_writedata_i  (d_writedata),
    .d_readdata_o   (d_readdata),
    .d_busywait_o   (d_busywait),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .mem_address_o  (mem_address),
    .mem_writedata_o(mem_writedata),
    .mem_readdata_i (mem_readdata),
    .mem_busywait_i (mem_busywait)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [0:63];
  logic        mem_loaded = 1'b0;
  int          busy_cnt = 0;

  assign mem_busywait = (mem_read | mem_write) && (busy_cnt != 5);
  assign mem_readdata = mem_arr[mem_address];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 64; k++) mem_arr[k] <= 32'h0;
      mem_arr[3] <= 32'hDEADBEEF;
      mem_arr[8] <= 32'hCAFEF00D;
      mem_loaded <= 1'b1;
    end
    if (!(mem_read | mem_write)) begin
      busy_cnt <= 0;
    end else if (busy_cnt < 5) begin
      busy_cnt <= busy_cnt + 1;
    end else if (mem_write) begin
      mem_arr[mem_address] <= mem_writedata;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir, dr, dw;
    logic [5:0]  ia, da;
    logic [31:0] wd;
    int          exp_i_cyc, exp_d_cyc, exp_wr_cyc;
    logic [5:0]  exp_wr_addr;
    logic [31:0] exp_i_data, exp_d_data;
  } vec_t;

  // Raise the requests, let each requester drop its request as soon as its
  // busywait falls, and record the cycle (edges after issue) of each event.
  task automatic run_vec(input vec_t v, input string name);
    int         i_done  = -1;
    int         d_done  = -1;
    int         wr_cyc  = -1;
    logic [5:0] wr_addr = 6'd0;
    logic       rw_both = 1'b0;
    i_read = v.ir; d_read = v.dr; d_write = v.dw;
    i_address = v.ia; d_address = v.da; d_writedata = v.wd;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (mem_write && wr_cyc < 0) begin
        wr_cyc  = c;
        wr_addr = mem_address;
      end
      if (mem_read && mem_write) rw_both = 1'b1;
      if (i_read && !i_busywait) begin
        i_done = c;
        i_read = 1'b0;
      end
      if ((d_read || d_write) && !d_busywait) begin
        d_done = c;
        d_read = 1'b0;
        d_write = 1'b0;
      end
      if ((!v.ir || i_done >= 0) && (!(v.dr || v.dw) || d_done >= 0)) break;
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    chk({name, ".i_cycle"}, i_done, v.exp_i_cyc);
    chk({name, ".d_cycle"}, d_done, v.exp_d_cyc);
    chk({name, ".wr_cycle"}, wr_cyc, v.exp_wr_cyc);
    chk({name, ".wr_addr"}, wr_addr, v.exp_wr_addr);
    chk({name, ".rw_both"}, rw_both, 1'b0);
    chk({name, ".i_data"}, i_readdata, v.exp_i_data);
    chk({name, ".d_data"}, d_readdata, v.exp_d_data);
    $display("txn %s i_cycle=%0d d_cycle=%0d wr_cycle=%0d i_data=%h d_data=%h",
             name, i_done, d_done, wr_cyc, i_readdata, d_readdata);
    repeat (2) @(posedge clk);
    #1;
  endtask

  vec_t vecs [6];

  initial begin
    int   comp_port [4];
    int   comp_cyc  [4];
    int   ncomp;
    int   fall;
    vec_t tie;

    //            ir   dr   dw   ia     da     wd            i_c d_c wr  wr_a   i_data        d_data
    vecs[0] = '{1'b1,1'b0,1'b0,6'h03,6'h00,32'h0,         7, -1, -1, 6'h00,32'hDEADBEEF,32'h00000000};
    vecs[1] = '{1'b0,1'b1,1'b0,6'h00,6'h08,32'h0,        -1,  7, -1, 6'h00,32'hDEADBEEF,32'hCAFEF00D};
    vecs[2] = '{1'b0,1'b0,1'b1,6'h00,6'h05,32'h11223344, -1,  7,  1, 6'h05,32'hDEADBEEF,32'hCAFEF00D};
    vecs[3] = '{1'b1,1'b0,1'b1,6'h05,6'h09,32'hA5A5A5A5,  7, 15,  9, 6'h09,32'h11223344,32'hCAFEF00D};
    vecs[4] = '{1'b1,1'b1,1'b0,6'h09,6'h03,32'h0,         7, 15, -1, 6'h00,32'hA5A5A5A5,32'hDEADBEEF};
    vecs[5] = '{1'b0,1'b1,1'b1,6'h00,6'h03,32'h0BADF00D, -1,  7,  1, 6'h03,32'hA5A5A5A5,32'hDEADBEEF};

    rst = 1'b1;
    i_read = 1'b0; i_address = 6'h0;
    d_read = 1'b0; d_write = 1'b0; d_address = 6'h0; d_writedata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.mem_read", mem_read, 1'b0);
    chk("reset.mem_write", mem_write, 1'b0);
    chk("reset.mem_address", mem_address, 6'h0);
    chk("reset.i_readdata", i_readdata, 32'h0);
    chk("reset.d_readdata", d_readdata, 32'h0);
    chk("reset.busywaits", {i_busywait, d_busywait}, 2'b00);
    $display("txn reset mem_read=%b mem_write=%b i_data=%h d_data=%h",
             mem_read, mem_write, i_readdata, d_readdata);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 6; n++) begin
      run_vec(vecs[n], $sformatf("vec%0d", n));
    end

    // Continuous requests from both ports: grants must alternate I, D, I, D.
    for (int k = 0; k < 4; k++) begin
      comp_port[k] = -1;
      comp_cyc[k]  = -1;
    end
    ncomp = 0;
    i_read = 1'b1; i_address = 6'h08;
    d_read = 1'b1; d_write = 1'b0; d_address = 6'h09;
    for (int c = 1; c <= 60 && ncomp < 4; c++) begin
      @(posedge clk); #1;
      if (!i_busywait && ncomp < 4) begin
        comp_port[ncomp] = 0; comp_cyc[ncomp] = c; ncomp++;
        chk("alt.i_data", i_readdata, 32'hCAFEF00D);
      end
      if (!d_busywait && ncomp < 4) begin
        comp_port[ncomp] = 1; comp_cyc[ncomp] = c; ncomp++;
        chk("alt.d_data", d_readdata, 32'hA5A5A5A5);
      end
    end
    i_read = 1'b0; d_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("alt.port%0d", k), comp_port[k], k % 2);
      chk($sformatf("alt.cycle%0d", k), comp_cyc[k], 7 + 8 * k);
      $display("txn alt%0d port=%0d cycle=%0d", k, comp_port[k], comp_cyc[k]);
    end
    repeat (2) @(posedge clk);
    #1;

    // I_READ withdrawn during the grant: transaction still runs to the end.
    i_read = 1'b1; i_address = 6'h03;
    @(posedge clk); #1;
    chk("withdraw.mem_read", mem_read, 1'b1);
    chk("withdraw.mem_address", mem_address, 6'h03);
    @(posedge clk); #1;
    i_read = 1'b0;
    fall = -1;
    for (int c = 3; c <= 20; c++) begin
      @(posedge clk); #1;
      if (!mem_read) begin
        fall = c;
        break;
      end
    end
    chk("withdraw.release_cycle", fall, 7);
    chk("withdraw.i_data", i_readdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("withdraw.idle_strobe", mem_read, 1'b0);
    $display("txn withdraw release_cycle=%0d i_data=%h", fall, i_readdata);
    @(posedge clk); #1;

    // Reset in the third busy cycle of a D read.
    d_read = 1'b1; d_address = 6'h08;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid.mem_read", mem_read, 1'b0);
    chk("rst_mid.mem_address", mem_address, 6'h0);
    chk("rst_mid.d_readdata", d_readdata, 32'h0);
    chk("rst_mid.i_readdata", i_readdata, 32'h0);
    $display("txn rst_mid mem_read=%b mem_address=%h d_data=%h", mem_read, mem_address, d_readdata);
    d_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.idle", {mem_read, mem_write}, 2'b00);

    // First tie after reset goes to I; the D write follows afterwards.
    tie = '{1'b1,1'b0,1'b1,6'h03,6'h05,32'h11223344, 7, 15, 9, 6'h05, 32'h0BADF00D, 32'h00000000};
    run_vec(tie, "post_reset_tie");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
